// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter
//   Round-robin arbiter that hands one 8-way decoded resource to one of 8
//   requesters at a time. The winner's index is registered as a 3-bit select
//   and mirrored as a one-hot grant for the downstream decode/enable logic.
//
// Parameters
//   HOLD_MAX  maximum grant tenure in cycles; 0 = unlimited
//   CW        tenure counter width, 2**CW > HOLD_MAX
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   lock       (ARB_LOCK_EN only) suppresses tenure-expiry release while high
//   req[7:0]   request vector, bit i held by requester i until done
//   gnt[7:0]   registered one-hot grant, zero when idle
//   gnt_valid  high while a grant is active (OR of gnt)
//   sel[2:0]   index of current owner; holds last owner when idle
//   timeout    one-cycle pulse when a tenure ended by HOLD_MAX expiry
//
// Optional feature macro: ARB_LOCK_EN (adds the lock input).
module rr_decode_arbiter #(
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned CW       = 5
) (
    input  logic       clk,
    input  logic       rst,
`ifdef ARB_LOCK_EN
    input  logic       lock,
`endif
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic       gnt_valid,
    output logic [2:0] sel,
    output logic       timeout
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [CW-1:0] HOLD_C  = CW'(HOLD_MAX);
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        state_q, state_d;
    logic [7:0]    gnt_q, gnt_d;
    logic [2:0]    sel_q, sel_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [CW-1:0] tenure_q, tenure_d;
    logic          timeout_q, timeout_d;

    logic          found;
    logic [2:0]    win;
    logic [2:0]    idx;
    logic          lock_hold;
    logic          hold_expire;
    logic          rel_a;
    logic          rel_b;

`ifdef ARB_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    // First set request scanning upward from ptr; 3-bit index wraps 7 -> 0.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int i = 0; i < 8; i++) begin
            idx = ptr_q + 3'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign hold_expire = (HOLD_MAX != 0) && (tenure_q == HOLD_C);
    assign rel_a       = !req[sel_q];
    assign rel_b       = hold_expire && !lock_hold;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        tenure_d  = tenure_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = BUSY;
                    sel_d    = win;
                    gnt_d    = 8'd1 << win;
                    tenure_d = CW'(1);
                end
            end
            BUSY: begin
                if (rel_a || rel_b) begin
                    state_d   = IDLE;
                    gnt_d     = 8'd0;
                    ptr_d     = sel_q + 3'd1;
                    tenure_d  = '0;
                    // Owner dropping its request wins over a coincident expiry.
                    timeout_d = !rel_a;
                end else if (tenure_q != CNT_MAX && !hold_expire) begin
                    // Saturate: at CNT_MAX when unlimited, at HOLD_MAX when locked.
                    tenure_d = tenure_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 8'd0;
            sel_q     <= 3'd0;
            ptr_q     <= 3'd0;
            tenure_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            tenure_q  <= tenure_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign sel       = sel_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Testbench for rr_decode_arbiter: directed scenarios followed by random
// request/reset traffic, every cycle compared against a behavioural model.
module tb_rr_decode_arbiter;
    localparam int HM = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'd0;
`ifdef ARB_LOCK_EN
    logic       lock = 1'b0;
`endif
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] sel;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int m_owner = -1;
    int m_sel   = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;
    int m_to    = 0;

    always #5 clk = ~clk;

    rr_decode_arbiter #(.HOLD_MAX(HM), .CW(5)) u_dut (
        .clk       (clk),
        .rst       (rst),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .sel       (sel),
        .timeout   (timeout)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit lk;
`ifdef ARB_LOCK_EN
        lk = lock;
`else
        lk = 1'b0;
`endif
        if (rst) begin
            m_owner = -1; m_sel = 0; m_ptr = 0; m_cnt = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (m_owner < 0) begin
                for (int k = 0; k < 8; k++) begin
                    int j;
                    j = (m_ptr + k) % 8;
                    if (m_owner < 0 && req[j]) m_owner = j;
                end
                if (m_owner >= 0) begin
                    m_sel = m_owner;
                    m_cnt = 1;
                end
            end else if (!req[m_owner]) begin
                m_ptr = (m_owner + 1) % 8; m_owner = -1; m_cnt = 0;
            end else if (m_cnt == HM && !lk) begin
                m_ptr = (m_owner + 1) % 8; m_owner = -1; m_cnt = 0; m_to = 1;
            end else if (m_cnt < HM) begin
                m_cnt++;
            end
        end
    endtask

    task automatic cycle();
        logic [7:0] eg;
        @(posedge clk);
        model_step();
        #1;
        eg = (m_owner < 0) ? 8'd0 : 8'(1 << m_owner);
        check("gnt", gnt, eg);
        check("gnt_valid", {7'd0, gnt_valid}, {7'd0, m_owner >= 0});
        check("sel", {5'd0, sel}, 8'(m_sel));
        check("timeout", {7'd0, timeout}, 8'(m_to));
    endtask

    initial begin
        // reset
        rst = 1'b1; req = 8'd0;
        cycle(); cycle();
        rst = 1'b0;
        cycle();

        // single requester 2, held 3 cycles then dropped
        req = 8'b0000_0100;
        cycle();
        check("req2_gnt", gnt, 8'h04);
        cycle(); cycle();
        req = 8'd0;
        cycle();
        check("req2_drop", gnt, 8'h00);
        // ptr now 3: requests 0 and 1 wrap to 0
        req = 8'b0000_0011;
        cycle();
        check("wrap_gnt", gnt, 8'h01);
        req = 8'd0;
        cycle(); cycle();

        // reset to ptr 0 then all requesting: 0..7,0 with HM-cycle tenures
        rst = 1'b1; cycle(); rst = 1'b0;
        req = 8'hFF;
        for (int c = 0; c < 8 * (HM + 1) + 3; c++) cycle();

        // run until owner 6 holds the grant, then reset mid-tenure
        for (int c = 0; c < 60 && m_owner != 6; c++) cycle();
        check("reach_owner6", gnt, 8'h40);
        rst = 1'b1;
        cycle();
        check("rst_mid_gnt", gnt, 8'h00);
        rst = 1'b0;
        req = 8'h41;
        cycle();
        check("after_rst_gnt", gnt, 8'h01);
        req = 8'd0;
        cycle(); cycle();

        // sole requester 5 held: grant, timeout, one idle, regrant
        req = 8'h20;
        for (int c = 0; c < 3 * (HM + 1) + 1; c++) cycle();
        req = 8'd0;
        cycle(); cycle();

`ifdef ARB_LOCK_EN
        // lock keeps requester 1 past HOLD_MAX; timeout once lock drops
        rst = 1'b1; cycle(); rst = 1'b0;
        req = 8'h02; lock = 1'b1;
        for (int c = 0; c < HM + 4; c++) cycle();
        check("lock_hold", gnt, 8'h02);
        lock = 1'b0;
        cycle();
        check("lock_release_to", {7'd0, timeout}, 8'h01);
        req = 8'd0;
        cycle(); cycle();
`endif

        // random traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) req = 8'd0;
            rst = ($urandom_range(0, 63) == 0);
`ifdef ARB_LOCK_EN
            if ($urandom_range(0, 7) == 0) lock = ~lock;
`endif
            cycle();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
